// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path: opcodes, FSM state
// encodings and datapath mux select codes. The immediate decoder reuses the opcodes.
package riscv_ctrl_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    // Fixed 4-bit state encodings; codes 11-15 are unused
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_t;

    // ResultSrc codes
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // ALUSrcA codes
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // ALUOp codes
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode: datapath enables and selects from the current state.
// MemReady only matters in FETCH and Zero only in BEQ.
module ctrl_out_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write
);

    logic pc_update;
    logic branch;

    // Per-state output table; anything not set for a state stays 0
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRd2;
        alu_op     = AluAdd;
        reg_write  = 1'b0;
        case (state)
            StFetch: begin
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            StDecode: begin
                // PC-relative branch target parked in ALUOut
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                alu_src_a = SrcARd1;
                alu_op    = AluFunct;
            end
            StExecI: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StJal: begin
                // Link value PC+4 computed now; PC loads the jump target from ALUOut
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_update = 1'b1;
            end
            StBeq: begin
                alu_src_a = SrcARd1;
                alu_op    = AluSub;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: state register, next-state logic and
// reset gating of the write enables around the combinational output decode.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    logic   illegal;

    logic   pc_write;
    logic   mem_write;
    logic   ir_write;
    logic   reg_write;

    // State register; asynchronous reset aborts any instruction in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; OP is only looked at in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            StFetch:    if (MemReady) state_d = StDecode;
            StDecode: begin
                case (OP)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecR;
                    OpI:        state_d = StExecI;
                    OpJal:      state_d = StJal;
                    OpBeq:      state_d = StBeq;
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr:   state_d = (OP == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (MemReady) state_d = StMemWb;
            StMemWrite: if (MemReady) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StMemWb:    state_d = StFetch;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    ctrl_out_decode u_ctrl_out_decode (
        .state      (state_q),
        .mem_ready  (MemReady),
        .zero       (Zero),
        .pc_write   (pc_write),
        .adr_src    (AdrSrc),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (ResultSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .alu_op     (ALUOp),
        .reg_write  (reg_write)
    );

    // Enables are qualified by RST so FETCH's MemReady-driven strobes stay low in reset
    assign PCWrite   = pc_write & RST;
    assign MemWrite  = mem_write & RST;
    assign IRWrite   = ir_write & RST;
    assign RegWrite  = reg_write & RST;
    assign IllegalOp = illegal & RST;
    assign State     = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle RV32I integer core. It is a Moore state machine that sequences one instruction at a time through fetch, decode, execute, memory and writeback over shared datapath resources: one ALU, one unified memory port and the instruction/data registers. It drives every datapath enable and mux select except ImmSrc, which stays with the standalone combinational immediate decoder.

## Interface
- No parameters. State encoding is fixed in the shared package.
- CLK  in  1  core clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- OP  in  7  instruction register bits [6:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory port completed the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1 register.
- ALUSrcB  out  2  00 = RD2 register, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode from funct fields.
- RegWrite  out  1  register file write enable.
- IllegalOp  out  1  unrecognised opcode seen in DECODE.
- State  out  4  current state, debug only.

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10. Codes 11–15 are unused and go to FETCH next cycle with all enables 0.
- Transitions:
  - FETCH → DECODE when MemReady = 1, else stay.
  - DECODE → MEMADR for lw or sw, EXECR for R, EXECI for I, JAL for jal, BEQ for beq.
  - DECODE → FETCH for any other opcode, with IllegalOp = 1 for that cycle.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when MemReady = 1, else stay.
  - MEMWRITE → FETCH when MemReady = 1, else stay.
  - EXECR and EXECI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Outputs per state. Any output not listed is 0.
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10. IRWrite and PCUpdate both equal MemReady.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. Branch target goes to ALUOut.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1. The strobe is held until MemReady.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1. PC is loaded from ALUOut.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
- PCWrite = PCUpdate | (Branch & Zero).
- OP is sampled only in DECODE and MEMADR. The instruction register is stable there because IRWrite = 0.

## Timing
- Only the state register is clocked. All outputs are combinational from the state, plus MemReady (FETCH only), Zero (BEQ only) and OP (DECODE only). There are no extra registers.
- Cycle counts with zero memory wait: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Each memory-wait cycle adds one cycle to the state it occurs in. No write or enable pulses repeat while waiting.
- Reset:
  - While RST = 0, State = FETCH.
  - PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0.
  - The selects show FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
- Reset asserted mid-instruction: abort immediately. No write enable may glitch high during or after the reset edge.
- After reset release, the first fetch is the first rising CLK edge with MemReady = 1.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants;
  - the 4-bit state encodings;
  - the ResultSrc, ALUSrcA, ALUSrcB and ALUOp code constants.
  The immediate decoder uses the same opcode constants.
- One natural sub-module, `ctrl_out_decode`: a purely combinational decode from State, MemReady and Zero to the output signals. The FSM top holds the state register and the next-state logic.

## Test plan
- Reset then lw (OP 0000011), MemReady always 1: State sequence 0,1,2,3,4,0. RegWrite = 1 only in state 4, with ResultSrc 01.
- sw with MemReady low for 3 cycles in MEMWRITE: MemWrite = 1 for 4 consecutive cycles, then State = 0. RegWrite stays 0 throughout.
- R-type (0110011) then I-type (0010011): ALUOp 10 in EXECR and in EXECI. ALUSrcB is 00 in EXECR and 01 in EXECI. RegWrite pulses once in ALUWB for each instruction.
- beq run twice, once with Zero = 1 and once with Zero = 0: PCWrite = 1 in BEQ only when Zero = 1. Both runs take 3 cycles.
- jal: PCWrite = 1 in JAL, then RegWrite = 1 in ALUWB, then return to FETCH.
- OP 1111111 gives IllegalOp = 1 in DECODE, then FETCH, with no write enables asserted. RST pulled low while in MEMWRITE forces MemWrite to 0 immediately and State to 0.
